// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 fetch/execute sequencer and its decoder.
package td4_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StHalt  = 2'd3
    } state_e;

    // Bit positions inside the active-low LOAD_N strobe vector.
    localparam int unsigned LD_A   = 0;
    localparam int unsigned LD_B   = 1;
    localparam int unsigned LD_OUT = 2;
    localparam int unsigned LD_PC  = 3;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

endpackage

// File: rtl/td4_sequencer_decoder.sv
// Classic TD4 gate-level instruction decoder: opcode + carry flag to
// active-low register loads and ALU source select.
module td4_sequencer_decoder
    import td4_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_cf,
    output logic [3:0] o_load_n,
    output logic [1:0] o_select
);

    assign o_select[0] = i_op[0] | i_op[3];
    assign o_select[1] = i_op[1];

    assign o_load_n[LD_A]   = i_op[2] | i_op[3];
    assign o_load_n[LD_B]   = ~i_op[2] | i_op[3];
    assign o_load_n[LD_OUT] = i_op[2] | ~i_op[3];
    // JNC (op[0]=0) suppresses the PC load while the carry flag is set.
    assign o_load_n[LD_PC]  = ~i_op[2] | ~i_op[3] | (~i_op[0] & i_cf);

endmodule

// File: rtl/td4_sequencer.sv
// Multi-cycle fetch/execute controller for the TD4 datapath: handshaked ROM
// fetch, one-cycle execute strobes, run/step/stop control and ROM timeout fault.
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned ROM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_halt_req,
    output logic              o_rom_req,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    input  logic              i_rom_valid,
    input  logic [3:0]        i_alu_sum,
    input  logic              i_alu_carry,
    output logic [3:0]        o_im,
    output logic [3:0]        o_load_n,
    output logic [1:0]        o_select,
    output logic              o_cf,
    output logic              o_busy,
    output logic              o_fault,
    output logic [CNT_W-1:0]  o_instr_cnt
);

    localparam logic [7:0] TMO_LAST = 8'(ROM_TIMEOUT - 1);

    state_e             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_cf;
    logic [3:0]         r_op;
    logic [3:0]         r_im;
    logic               r_rom_req;
    logic               r_fault;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_tmo;
    logic               r_step_mode;

    logic [3:0]         w_dec_load_n;
    logic [1:0]         w_dec_select;
    logic               w_exec;

    td4_sequencer_decoder u_decoder (
        .i_op     (r_op),
        .i_cf     (r_cf),
        .o_load_n (w_dec_load_n),
        .o_select (w_dec_select)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_cf        <= 1'b0;
            r_op        <= '0;
            r_im        <= '0;
            r_rom_req   <= 1'b0;
            r_fault     <= 1'b0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_step_mode <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if ((i_run || i_step) && !i_halt_req) begin
                        r_state     <= StFetch;
                        r_rom_req   <= 1'b1;
                        r_step_mode <= i_step & ~i_run;
                    end
                end
                StFetch: begin
                    if (i_rom_valid) begin
                        r_op      <= i_rom_data[7:4];
                        r_im      <= i_rom_data[3:0];
                        r_tmo     <= '0;
                        r_rom_req <= 1'b0;
                        r_state   <= StExec;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                        if (r_tmo == TMO_LAST) begin
                            r_fault   <= 1'b1;
                            r_rom_req <= 1'b0;
                            r_state   <= StHalt;
                        end
                    end
                end
                StExec: begin
                    r_cf  <= i_alu_carry;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!w_dec_load_n[LD_PC]) begin
                        r_pc <= ADDR_W'(i_alu_sum);
                    end else begin
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                    if (i_halt_req || r_step_mode || !i_run) begin
                        r_state <= StIdle;
                    end else begin
                        r_state   <= StFetch;
                        r_rom_req <= 1'b1;
                    end
                end
                StHalt: begin
                    // Only reset leaves the fault state.
                    r_state <= StHalt;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_exec      = (r_state == StExec);
    assign o_load_n    = w_exec ? w_dec_load_n : 4'b1111;
    assign o_select    = w_exec ? w_dec_select : 2'b00;
    assign o_busy      = (r_state == StFetch) || (r_state == StExec);
    assign o_rom_req   = r_rom_req;
    assign o_rom_addr  = r_pc;
    assign o_im        = r_im;
    assign o_cf        = r_cf;
    assign o_fault     = r_fault;
    assign o_instr_cnt = r_cnt;

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_td4_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic       step;
    logic       halt_req;
    logic       rom_req;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       rom_valid;
    logic [3:0] alu_sum;
    logic       alu_carry;
    logic [3:0] im;
    logic [3:0] load_n;
    logic [1:0] sel;
    logic       cf;
    logic       busy;
    logic       fault;
    logic [7:0] instr_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference architectural state.
    logic [3:0] m_pc;
    logic       m_cf;
    logic [7:0] m_cnt;

    td4_sequencer #(
        .ADDR_W      (4),
        .ROM_TIMEOUT (15),
        .CNT_W       (8)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_run       (run),
        .i_step      (step),
        .i_halt_req  (halt_req),
        .o_rom_req   (rom_req),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .i_rom_valid (rom_valid),
        .i_alu_sum   (alu_sum),
        .i_alu_carry (alu_carry),
        .o_im        (im),
        .o_load_n    (load_n),
        .o_select    (sel),
        .o_cf        (cf),
        .o_busy      (busy),
        .o_fault     (fault),
        .o_instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction semantics: destination register and ALU source per opcode.
    function automatic void ref_ctrl(input logic [3:0] op, input logic c,
                                     output logic [3:0] ld, output logic [1:0] s,
                                     output logic jmp);
        int dest;
        dest = -1;
        s    = 2'b00;
        jmp  = 1'b0;
        case (op)
            4'h0: begin dest = 0; s = 2'b00; end  // ADD A,Im
            4'h1: begin dest = 0; s = 2'b01; end  // MOV A,B
            4'h2: begin dest = 0; s = 2'b10; end  // IN A
            4'h3: begin dest = 0; s = 2'b11; end  // MOV A,Im
            4'h4: begin dest = 1; s = 2'b00; end  // MOV B,A
            4'h5: begin dest = 1; s = 2'b01; end  // ADD B,Im
            4'h6: begin dest = 1; s = 2'b10; end  // IN B
            4'h7: begin dest = 1; s = 2'b11; end  // MOV B,Im
            4'h9: begin dest = 2; s = 2'b01; end  // OUT B
            4'hB: begin dest = 2; s = 2'b11; end  // OUT Im
            4'hE: begin s = 2'b11; if (!c) dest = 3; end  // JNC
            4'hF: begin dest = 3; s = 2'b11; end  // JMP
            default: dest = -1;
        endcase
        ld = 4'b1111;
        if (dest >= 0) ld[dest] = 1'b0;
        jmp = (dest == 3);
    endfunction

    // Serve one fetch after 'delay' idle ROM cycles, check the EXEC cycle and
    // the architectural effects. DUT must be in FETCH on entry.
    task automatic do_instr(input logic [7:0] instr, input int delay, input logic [3:0] sum,
                            input logic carry, input logic exp_fetch);
        logic [3:0] e_ld;
        logic [1:0] e_sel;
        logic       e_jmp;
        for (int i = 0; i < delay; i++) begin
            check_eq("wait_req", rom_req, 1);
            check_eq("wait_addr", rom_addr, m_pc);
            rom_data = 8'($urandom);
            tick();
        end
        check_eq("fetch_req", rom_req, 1);
        check_eq("fetch_addr", rom_addr, m_pc);
        rom_data  = instr;
        rom_valid = 1'b1;
        tick();
        rom_valid = 1'b0;
        rom_data  = 8'($urandom);
        ref_ctrl(instr[7:4], m_cf, e_ld, e_sel, e_jmp);
        check_eq("exec_load_n", load_n, e_ld);
        check_eq("exec_select", sel, e_sel);
        check_eq("exec_im", im, instr[3:0]);
        check_eq("exec_busy", busy, 1);
        check_eq("exec_req", rom_req, 0);
        alu_sum   = sum;
        alu_carry = carry;
        tick();
        m_pc  = e_jmp ? sum : m_pc + 4'd1;
        m_cf  = carry;
        m_cnt = m_cnt + 8'd1;
        check_eq("post_pc", rom_addr, m_pc);
        check_eq("post_cf", cf, m_cf);
        check_eq("post_cnt", instr_cnt, m_cnt);
        check_eq("post_idle_load_n", load_n, 4'hF);
        check_eq("post_req", rom_req, exp_fetch);
        check_eq("post_busy", busy, exp_fetch);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req"}, rom_req, 0);
        check_eq({tag, "_load_n"}, load_n, 4'hF);
        check_eq({tag, "_sel"}, sel, 0);
        check_eq({tag, "_pc"}, rom_addr, 0);
        check_eq({tag, "_cf"}, cf, 0);
        check_eq({tag, "_cnt"}, instr_cnt, 0);
        check_eq({tag, "_fault"}, fault, 0);
        check_eq({tag, "_busy"}, busy, 0);
        m_pc  = '0;
        m_cf  = 1'b0;
        m_cnt = '0;
    endtask

    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                             4'h6, 4'h7, 4'h9, 4'hB, 4'hE, 4'hF};

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        rom_data = '0; rom_valid = 1'b0; alu_sum = '0; alu_carry = 1'b0;
        tick();
        tick();
        check_reset_state("por");

        // Reset while a fetch is outstanding.
        reset = 1'b0; run = 1'b1;
        tick();
        check_eq("pre_rst_req", rom_req, 1);
        tick();
        tick();
        reset = 1'b1; run = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("mid_fetch_rst");

        // Run mode: immediate fetch, jumps, wrap, conditional jump both ways.
        run = 1'b1;
        tick();
        do_instr(8'h03, 0, 4'd3, 1'b0, 1'b1);
        do_instr(8'h35, 0, 4'd8, 1'b0, 1'b1);
        do_instr(8'hF5, 1, 4'd5, 1'b0, 1'b1);
        do_instr(8'hFF, 0, 4'd15, 1'b0, 1'b1);
        do_instr(8'h03, 2, 4'd7, 1'b0, 1'b1);
        check_eq("wrap_pc", rom_addr, 0);
        do_instr(8'h51, 0, 4'd2, 1'b1, 1'b1);
        do_instr(8'hE9, 0, 4'd9, 1'b0, 1'b1);
        do_instr(8'hE9, 0, 4'd9, 1'b0, 1'b1);
        check_eq("jnc_taken_pc", rom_addr, 9);
        // Longest legal fetch latency must not fault.
        do_instr(8'h73, 14, 4'd1, 1'b0, 1'b1);
        check_eq("no_fault_at_14", fault, 0);
        // RUN drops mid-fetch: instruction completes, then idle.
        tick();
        run = 1'b0;
        do_instr(8'hB2, 1, 4'd4, 1'b1, 1'b0);

        // ROM_VALID in IDLE is ignored.
        rom_valid = 1'b1; rom_data = 8'hFF;
        tick();
        rom_valid = 1'b0;
        check_eq("idle_valid_busy", busy, 0);
        check_eq("idle_valid_cnt", instr_cnt, m_cnt);
        check_eq("idle_valid_pc", rom_addr, m_pc);

        // Single step with delayed ROM.
        step = 1'b1;
        tick();
        step = 1'b0;
        do_instr(8'h96, 3, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("step_stays_idle", busy, 0);
        check_eq("step_cnt", instr_cnt, m_cnt);

        // HALT_REQ blocks a start, and stops a running stream at the boundary.
        halt_req = 1'b1; run = 1'b1;
        tick();
        check_eq("halt_blocks_start", busy, 0);
        halt_req = 1'b0;
        tick();
        halt_req = 1'b1;
        do_instr(8'h2A, 1, 4'd6, 1'b0, 1'b0);
        halt_req = 1'b0; run = 1'b0;
        tick();
        check_eq("halt_idle_busy", busy, 0);

        // ROM timeout: 15 fetch cycles with no response.
        run = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            check_eq("tmo_req", rom_req, 1);
            check_eq("tmo_fault_early", fault, 0);
            tick();
        end
        check_eq("tmo_fault", fault, 1);
        check_eq("tmo_req_drop", rom_req, 0);
        check_eq("tmo_busy", busy, 0);
        step = 1'b1; rom_valid = 1'b1;
        tick();
        step = 1'b0; rom_valid = 1'b0;
        tick();
        tick();
        check_eq("halt_sticky_fault", fault, 1);
        check_eq("halt_sticky_busy", busy, 0);
        check_eq("halt_sticky_req", rom_req, 0);
        run = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("fault_rst");

        // Randomized instruction stream.
        run = 1'b1;
        tick();
        for (int k = 0; k < 40; k++) begin
            logic [7:0] ins;
            logic       last;
            ins  = {ops[$urandom_range(0, 11)], 4'($urandom)};
            last = (k == 39);
            if (last) run = 1'b0;
            do_instr(ins, int'($urandom_range(0, 4)), 4'($urandom), 1'($urandom), !last);
        end
        check_eq("rand_final_fault", fault, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
